// File: rtl/multicycle_control_if.sv
// Shared memory port between the sequencing controller and memory.
// The controller is the master; memory answers with mem_ack.
interface multicycle_control_if;
    logic mem_req;
    logic mem_ack;
    logic mem_addr_sel;
    logic Mem_WrEn;
    logic sb;

    modport master (
        output mem_req,
        output mem_addr_sel,
        output Mem_WrEn,
        output sb,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr_sel,
        input  Mem_WrEn,
        input  sb,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-style datapath: IF/DEC/EXEC/BR/MEM/WB,
// sharing one memory port between fetch and data access.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b100000,
    parameter logic [3:0] SUB_FUNC = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    multicycle_control_if.master mem,
    output logic        IR_LdEn,
    output logic        MDR_LdEn,
    output logic        ALUout_LdEn,
    output logic        PC_sel,
    output logic        PC_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        lui,
    output logic        lb,
    output logic        illegal,
    output logic [2:0]  state
);

    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_SB   = 6'b000111;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_DEC  = 3'd1,
        S_EXEC = 3'd2,
        S_BR   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [5:0] op;
    logic is_nop, is_r, is_li, is_lui, is_addi;
    logic is_andi, is_ori, is_b, is_beq, is_bne;
    logic is_lb, is_sb, is_lw, is_sw, is_ill;
    logic is_br, is_ld, is_st;

    logic req_r, addr_r, ir_r, mdr_r, aluout_r;
    logic pc_sel_r, pc_ld_r, rf_wr_r, wd_sel_r;
    logic b_sel_r, bin_r, wr_r, lui_r, lb_r, sb_r;
    logic [3:0] func_r;

    logic unused_instr;
    assign unused_instr = ^Instr[25:4];

    assign op     = Instr[31:26];
    assign is_nop = (Instr == 32'd0);

    always_comb begin
        is_r    = 1'b0;
        is_li   = 1'b0;
        is_lui  = 1'b0;
        is_addi = 1'b0;
        is_andi = 1'b0;
        is_ori  = 1'b0;
        is_b    = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_lb   = 1'b0;
        is_sb   = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_ill  = 1'b0;
        unique case (op)
            OP_RTYPE: is_r    = 1'b1;
            OP_LI:    is_li   = 1'b1;
            OP_LUI:   is_lui  = 1'b1;
            OP_ADDI:  is_addi = 1'b1;
            OP_ANDI:  is_andi = 1'b1;
            OP_ORI:   is_ori  = 1'b1;
            OP_B:     is_b    = 1'b1;
            OP_BEQ:   is_beq  = 1'b1;
            OP_BNE:   is_bne  = 1'b1;
            OP_LB:    is_lb   = 1'b1;
            OP_SB:    is_sb   = 1'b1;
            OP_LW:    is_lw   = 1'b1;
            OP_SW:    is_sw   = 1'b1;
            default:  is_ill  = 1'b1;
        endcase
    end

    assign is_br = is_b | is_beq | is_bne;
    assign is_ld = is_lb | is_lw;
    assign is_st = is_sb | is_sw;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        req_r     = 1'b0;
        addr_r    = 1'b0;
        ir_r      = 1'b0;
        mdr_r     = 1'b0;
        aluout_r  = 1'b0;
        pc_sel_r  = 1'b0;
        pc_ld_r   = 1'b0;
        rf_wr_r   = 1'b0;
        wd_sel_r  = 1'b0;
        b_sel_r   = 1'b0;
        bin_r     = 1'b0;
        func_r    = 4'd0;
        wr_r      = 1'b0;
        lui_r     = 1'b0;
        lb_r      = 1'b0;
        sb_r      = 1'b0;
        case (state_q)
            S_IF: begin
                req_r = 1'b1;
                if (mem.mem_ack) begin
                    ir_r    = 1'b1;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                // Instr==0 shares the beq opcode, so nop wins first.
                if (is_nop || is_ill) begin
                    pc_ld_r   = 1'b1;
                    illegal_d = illegal_q | (is_ill & ~is_nop);
                    state_d   = S_IF;
                end else if (is_br) begin
                    state_d = S_BR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                aluout_r = 1'b1;
                b_sel_r  = is_st;
                lui_r    = is_lui;
                unique case (1'b1)
                    is_r:    func_r = Instr[3:0];
                    is_andi: begin
                        func_r = 4'b0010;
                        bin_r  = 1'b1;
                    end
                    is_ori: begin
                        func_r = 4'b0011;
                        bin_r  = 1'b1;
                    end
                    default: bin_r = 1'b1;
                endcase
                state_d = (is_ld || is_st) ? S_MEM : S_WB;
            end
            S_BR: begin
                b_sel_r  = 1'b1;
                func_r   = SUB_FUNC;
                pc_ld_r  = 1'b1;
                pc_sel_r = is_b | (is_beq & Zero) | (is_bne & ~Zero);
                state_d  = S_IF;
            end
            S_MEM: begin
                req_r  = 1'b1;
                addr_r = 1'b1;
                wr_r   = is_st;
                sb_r   = is_sb;
                if (mem.mem_ack) begin
                    if (is_ld) begin
                        mdr_r   = 1'b1;
                        state_d = S_WB;
                    end else begin
                        pc_ld_r = 1'b1;
                        state_d = S_IF;
                    end
                end
            end
            S_WB: begin
                rf_wr_r  = 1'b1;
                wd_sel_r = is_ld;
                lb_r     = is_lb;
                lui_r    = is_lui;
                pc_ld_r  = 1'b1;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset masks every output in the same cycle, abandoning any access.
    assign mem.mem_req      = req_r & ~reset;
    assign mem.mem_addr_sel = addr_r & ~reset;
    assign mem.Mem_WrEn     = wr_r & ~reset;
    assign mem.sb           = sb_r & ~reset;
    assign IR_LdEn          = ir_r & ~reset;
    assign MDR_LdEn         = mdr_r & ~reset;
    assign ALUout_LdEn      = aluout_r & ~reset;
    assign PC_sel           = pc_sel_r & ~reset;
    assign PC_LdEn          = pc_ld_r & ~reset;
    assign RF_WrEn          = rf_wr_r & ~reset;
    assign RF_WrData_sel    = wd_sel_r & ~reset;
    assign RF_B_sel         = b_sel_r & ~reset;
    assign ALU_Bin_sel      = bin_r & ~reset;
    assign ALU_func         = reset ? 4'd0 : func_r;
    assign lui              = lui_r & ~reset;
    assign lb               = lb_r & ~reset;
    assign illegal          = illegal_q & ~reset;
    assign state            = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table vectors, corner
// sequences and random instructions against a transaction-level model.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'd0;
    logic        Zero = 1'b0;
    logic        IR_LdEn, MDR_LdEn, ALUout_LdEn, PC_sel, PC_LdEn;
    logic        RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        lui, lb, illegal;
    logic [2:0]  state;

    multicycle_control_if bus();

    always #5 clk = ~clk;

    multicycle_control #(
        .OP_RTYPE(6'b100000),
        .SUB_FUNC(4'b0001)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Instr(Instr),
        .Zero(Zero),
        .mem(bus),
        .IR_LdEn(IR_LdEn),
        .MDR_LdEn(MDR_LdEn),
        .ALUout_LdEn(ALUout_LdEn),
        .PC_sel(PC_sel),
        .PC_LdEn(PC_LdEn),
        .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel),
        .RF_B_sel(RF_B_sel),
        .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func),
        .lui(lui),
        .lb(lb),
        .illegal(illegal),
        .state(state)
    );

    typedef struct packed {
        logic       mem_req;
        logic       addr_sel;
        logic       ir_ld;
        logic       mdr_ld;
        logic       aluout_ld;
        logic       pc_sel;
        logic       pc_ld;
        logic       rf_wr;
        logic       rf_wd_sel;
        logic       rf_b_sel;
        logic       bin_sel;
        logic [3:0] func;
        logic       mem_wr;
        logic       lui;
        logic       lb;
        logic       sb;
        logic       illegal;
        logic [2:0] state;
    } ov_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        zero;
        logic        ack;
        ov_t         exp;
        ov_t         care;
    } cyc_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          dif;
        int          dmem;
        int          lat;
        logic        pcsel;
        int          nrf;
        logic        wr;
    } vec_t;

    typedef enum {K_NOP, K_ILL, K_BR, K_ALU, K_LD, K_ST} kind_e;

    ov_t  act;
    cyc_t q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    logic sticky = 1'b0;
    int   obs_npc, obs_lat, obs_nrf;
    logic obs_pcsel, obs_wr;

    assign act = {bus.mem_req, bus.mem_addr_sel, IR_LdEn, MDR_LdEn,
                  ALUout_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel,
                  RF_B_sel, ALU_Bin_sel, ALU_func, bus.Mem_WrEn, lui,
                  lb, bus.sb, illegal, state};

    function automatic kind_e kind_of(input logic [31:0] ins);
        if (ins == 32'd0) return K_NOP;
        case (ins[31:26])
            6'b111111, 6'b000000, 6'b000001: return K_BR;
            6'b000011, 6'b001111:            return K_LD;
            6'b000111, 6'b011111:            return K_ST;
            6'b100000, 6'b111000, 6'b111001,
            6'b110000, 6'b110010, 6'b110011: return K_ALU;
            default:                         return K_ILL;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [31:0] ins,
                                   input logic [2:0] st);
        cyc_t c;
        c.instr       = ins;
        c.zero        = 1'($urandom);
        c.ack         = 1'($urandom);
        c.exp         = '0;
        c.exp.state   = st;
        c.exp.illegal = sticky;
        c.care        = '1;
        return c;
    endfunction

    // Expands one instruction into the cycles it should take.
    task automatic expand(input logic [31:0] ins, input logic z,
                          input int dif, input int dmem);
        kind_e      k;
        logic [5:0] op;
        cyc_t       c;
        k  = kind_of(ins);
        op = ins[31:26];
        for (int i = 0; i <= dif; i++) begin
            c = blank($urandom, 3'd0);
            c.ack = (i == dif);
            c.exp.mem_req = 1'b1;
            c.exp.ir_ld = (i == dif);
            q.push_back(c);
        end
        c = blank(ins, 3'd1);
        c.exp.pc_ld = (k == K_NOP || k == K_ILL);
        q.push_back(c);
        if (k == K_ILL) sticky = 1'b1;
        if (k == K_BR) begin
            c = blank(ins, 3'd3);
            c.zero = z;
            c.exp.rf_b_sel = 1'b1;
            c.exp.func = 4'b0001;
            c.exp.pc_ld = 1'b1;
            c.exp.pc_sel = (op == 6'b111111) ? 1'b1 :
                           (op == 6'b000000) ? z : ~z;
            q.push_back(c);
        end
        if (k == K_ALU || k == K_LD || k == K_ST) begin
            c = blank(ins, 3'd2);
            c.exp.aluout_ld = 1'b1;
            c.exp.lui = (op == 6'b111001);
            c.exp.bin_sel = (op != 6'b100000);
            c.exp.func = (op == 6'b100000) ? ins[3:0] :
                         (op == 6'b110010) ? 4'b0010 :
                         (op == 6'b110011) ? 4'b0011 : 4'b0000;
            c.care.rf_b_sel = 1'b0;
            if (op == 6'b110010 || op == 6'b110011) c.care.bin_sel = 1'b0;
            q.push_back(c);
        end
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i <= dmem; i++) begin
                c = blank(ins, 3'd4);
                c.ack = (i == dmem);
                c.exp.mem_req = 1'b1;
                c.exp.addr_sel = 1'b1;
                c.exp.mem_wr = (k == K_ST);
                c.exp.sb = (op == 6'b000111);
                c.exp.mdr_ld = (i == dmem) && (k == K_LD);
                c.exp.pc_ld = (i == dmem) && (k == K_ST);
                q.push_back(c);
            end
        end
        if (k == K_ALU || k == K_LD) begin
            c = blank(ins, 3'd5);
            c.exp.rf_wr = 1'b1;
            c.exp.rf_wd_sel = (k == K_LD);
            c.exp.lb = (op == 6'b000011);
            c.exp.lui = (op == 6'b111001);
            c.exp.pc_ld = 1'b1;
            q.push_back(c);
        end
    endtask

    task automatic step(input cyc_t c, input int idx);
        @(posedge clk);
        #1;
        reset = 1'b0;
        Instr = c.instr;
        Zero = c.zero;
        bus.mem_ack = c.ack;
        #3;
        checks++;
        if (((act ^ c.exp) & c.care) != '0) begin
            failures++;
            $display("FAIL cycle%0d instr=%h got=%h want=%h care=%h",
                     idx, c.instr, act, c.exp, c.care);
        end
        if (act.pc_ld) begin
            obs_npc++;
            obs_lat = idx + 1;
            obs_pcsel = act.pc_sel;
        end
        if (act.rf_wr) obs_nrf++;
        if (act.mem_wr) obs_wr = 1'b1;
    endtask

    task automatic run_q(input int limit);
        int n;
        n = (limit < q.size()) ? limit : q.size();
        obs_npc = 0;
        obs_lat = 0;
        obs_nrf = 0;
        obs_pcsel = 1'b0;
        obs_wr = 1'b0;
        for (int i = 0; i < n; i++) step(q[i], i);
        q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        Instr = $urandom;
        Zero = 1'b1;
        bus.mem_ack = 1'b1;
        #3;
        checks++;
        if (act != '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", act);
        end
        sticky = 1'b0;
    endtask

    task automatic check_int(input string name, input int got,
                             input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic add_vec(input logic [31:0] ins, input logic z,
                           input int dif, input int dmem, input int lat,
                           input logic pcsel, input int nrf,
                           input logic wr);
        vec_t v;
        v.instr = ins;
        v.zero = z;
        v.dif = dif;
        v.dmem = dmem;
        v.lat = lat;
        v.pcsel = pcsel;
        v.nrf = nrf;
        v.wr = wr;
        tbl.push_back(v);
    endtask

    logic [5:0] ops [12];
    cyc_t       c0;

    initial begin
        bus.mem_ack = 1'b0;
        ops = '{6'b100000, 6'b111000, 6'b111001, 6'b110000,
                6'b110010, 6'b110011, 6'b111111, 6'b000000,
                6'b000001, 6'b000011, 6'b000111, 6'b001111};

        add_vec(32'hC0000005, 1'b0, 3, 0, 7, 1'b0, 1, 1'b0);
        add_vec(32'h80000003, 1'b0, 0, 0, 4, 1'b0, 1, 1'b0);
        add_vec(32'h00010004, 1'b1, 0, 0, 3, 1'b1, 0, 1'b0);
        add_vec(32'h00010004, 1'b0, 0, 0, 3, 1'b0, 0, 1'b0);
        add_vec(32'h04010004, 1'b1, 0, 0, 3, 1'b0, 0, 1'b0);
        add_vec(32'h04010004, 1'b0, 0, 0, 3, 1'b1, 0, 1'b0);
        add_vec(32'hFC000010, 1'b0, 0, 0, 3, 1'b1, 0, 1'b0);
        add_vec(32'h3C000008, 1'b0, 0, 2, 7, 1'b0, 1, 1'b0);
        add_vec(32'h1C000004, 1'b0, 0, 0, 4, 1'b0, 0, 1'b1);
        add_vec(32'h7C000004, 1'b0, 1, 1, 6, 1'b0, 0, 1'b1);
        add_vec(32'h0C000002, 1'b0, 0, 0, 5, 1'b0, 1, 1'b0);
        add_vec(32'hC8000001, 1'b0, 0, 0, 4, 1'b0, 1, 1'b0);
        add_vec(32'hCC000001, 1'b0, 2, 0, 6, 1'b0, 1, 1'b0);
        add_vec(32'hE0000007, 1'b0, 0, 0, 4, 1'b0, 1, 1'b0);
        add_vec(32'hE4000007, 1'b0, 0, 0, 4, 1'b0, 1, 1'b0);
        add_vec(32'h00000000, 1'b0, 0, 0, 2, 1'b0, 0, 1'b0);
        add_vec(32'h54000000, 1'b0, 1, 0, 3, 1'b0, 0, 1'b0);
        add_vec(32'hC0000001, 1'b0, 0, 0, 4, 1'b0, 1, 1'b0);

        do_reset();
        do_reset();

        foreach (tbl[i]) begin
            expand(tbl[i].instr, tbl[i].zero, tbl[i].dif, tbl[i].dmem);
            run_q(1000);
            check_int($sformatf("lat[%0d]", i),
                      (obs_npc == 1) ? obs_lat : -1, tbl[i].lat);
            check_int($sformatf("pcsel[%0d]", i),
                      int'(obs_pcsel), int'(tbl[i].pcsel));
            check_int($sformatf("rfwr[%0d]", i), obs_nrf, tbl[i].nrf);
            check_int($sformatf("memwr[%0d]", i),
                      int'(obs_wr), int'(tbl[i].wr));
        end

        // Illegal flag is still set here; reset must clear it.
        do_reset();

        // Reset in the middle of a stalled sw data access.
        expand(32'h7C000004, 1'b0, 0, 3);
        run_q(5);
        do_reset();
        c0 = blank($urandom, 3'd0);
        c0.ack = 1'b0;
        c0.exp.mem_req = 1'b1;
        q.push_back(c0);
        run_q(1);
        check_int("abandon_pcld", obs_npc, 0);

        for (int n = 0; n < 250; n++) begin
            int         sel;
            logic [31:0] ins;
            sel = $urandom_range(0, 13);
            if (sel < 12) ins = {ops[sel], 26'($urandom)};
            else if (sel == 12) ins = 32'd0;
            else ins = {6'b010101, 26'($urandom)};
            if (ins == 32'd0 && sel != 12) ins = 32'd1;
            expand(ins, 1'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 2));
            run_q(1000);
            check_int("rand_pcld_once", obs_npc, 1);
            if ($urandom_range(0, 24) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
